// File: rtl/wb_responder_pkg.sv
// Shared types for the bounded Wishbone responder.
//   state_t  : per-channel FSM state (idle, waiting for a response decision, responding).
//   wb_req_t : latched request fields, sized to the widest supported bus. Narrower buses are
//              zero-extended on entry, so comparisons stay exact.
//   STALL_W  : stall-counter width for a given stall bound (at least one bit).
package wb_responder_pkg;

    localparam int unsigned ReqAddrMaxW = 64;
    localparam int unsigned ReqDataMaxW = 64;
    localparam int unsigned ReqSelMaxW  = ReqDataMaxW / 8;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    typedef struct packed {
        logic [ReqAddrMaxW-1:0] adr;
        logic                   we;
        logic [ReqSelMaxW-1:0]  sel;
        logic [ReqDataMaxW-1:0] dat;
    } wb_req_t;

    function automatic int unsigned STALL_W(input int unsigned max_stall);
        // A zero bound still needs a one-bit register that simply stays at 0.
        return (max_stall == 0) ? 1 : $clog2(max_stall + 1);
    endfunction

endpackage

// File: rtl/wb_responder_channel.sv
// One Wishbone classic slave channel with a bounded response delay.
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   cyc_i/stb_i/we_i   : master controls
//   adr_i/dat_i/sel_i  : master address, write data, byte selects
//   rsp_ready_i        : respond at this edge (otherwise stall, up to MAX_STALL cycles)
//   rsp_err_i          : make the response an ERR (only if ERR_ENABLE)
//   rsp_data_i         : read data returned for reads
//   ack_o/err_o/dat_o  : registered termination and read data, live only in the response cycle
//   violation_o        : sticky master protocol violation flag
//   txn_count_o        : saturating count of completed transactions
module wb_responder_channel
    import wb_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_STALL  = 3,
    parameter bit          ERR_ENABLE = 1'b0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic                    rsp_ready_i,
    input  logic                    rsp_err_i,
    input  logic [DATA_WIDTH-1:0]   rsp_data_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    violation_o,
    output logic [CNT_WIDTH-1:0]    txn_count_o
);

    localparam int unsigned       StallW   = STALL_W(MAX_STALL);
    localparam logic [StallW-1:0] StallMax = StallW'(MAX_STALL);

    state_t              state_q;
    wb_req_t             req_q;
    wb_req_t             bus_req;
    logic [StallW-1:0]   stall_q;
    logic                req_live;

    assign req_live = cyc_i & stb_i;

    always_comb begin
        bus_req     = '0;
        bus_req.adr = ReqAddrMaxW'(adr_i);
        bus_req.we  = we_i;
        bus_req.sel = ReqSelMaxW'(sel_i);
        bus_req.dat = ReqDataMaxW'(dat_i);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            req_q       <= '0;
            stall_q     <= '0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            dat_o       <= '0;
            violation_o <= 1'b0;
            txn_count_o <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_live) begin
                        req_q   <= bus_req;
                        stall_q <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // Abort wins over responding: a request that changed or vanished gets
                    // no termination at all.
                    if (!req_live || (bus_req != req_q)) begin
                        violation_o <= 1'b1;
                        state_q     <= StIdle;
                    end else if (rsp_ready_i || (stall_q == StallMax)) begin
                        state_q <= StResp;
                        if (ERR_ENABLE && rsp_err_i) begin
                            err_o <= 1'b1;
                        end else begin
                            ack_o <= 1'b1;
                        end
                        dat_o <= req_q.we ? '0 : rsp_data_i;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                StResp: begin
                    // The termination was already presented; a master that dropped the
                    // cycle meanwhile is flagged but the transfer still counts.
                    if (!req_live) begin
                        violation_o <= 1'b1;
                    end
                    if (txn_count_o != '1) begin
                        txn_count_o <= txn_count_o + 1'b1;
                    end
                    ack_o   <= 1'b0;
                    err_o   <= 1'b0;
                    dat_o   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_bounded_responder.sv
// Multi-channel bounded Wishbone classic responder. Each channel is an independent
// wb_responder_channel; flattened vectors carry channel c at slice c.
// Ports:
//   clock, reset                        : clock, synchronous active-high reset
//   wb_cyc/wb_stb/wb_we                 : per-channel master controls
//   wb_adr/wb_dat_mosi/wb_sel           : per-channel address, write data, byte selects
//   wb_dat_miso/wb_ack/wb_err           : per-channel read data and termination
//   rsp_ready/rsp_err/rsp_data          : per-channel response choice inputs
//   violation/txn_count                 : per-channel sticky violation and saturating count
module wb_bounded_responder
    import wb_responder_pkg::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_STALL  = 3,
    parameter bit          ERR_ENABLE = 1'b0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [CHANNELS-1:0]                 wb_cyc,
    input  logic [CHANNELS-1:0]                 wb_stb,
    input  logic [CHANNELS-1:0]                 wb_we,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]      wb_adr,
    input  logic [CHANNELS*DATA_WIDTH-1:0]      wb_dat_mosi,
    input  logic [CHANNELS*DATA_WIDTH/8-1:0]    wb_sel,
    output logic [CHANNELS*DATA_WIDTH-1:0]      wb_dat_miso,
    output logic [CHANNELS-1:0]                 wb_ack,
    output logic [CHANNELS-1:0]                 wb_err,
    input  logic [CHANNELS-1:0]                 rsp_ready,
    input  logic [CHANNELS-1:0]                 rsp_err,
    input  logic [CHANNELS*DATA_WIDTH-1:0]      rsp_data,
    output logic [CHANNELS-1:0]                 violation,
    output logic [CHANNELS*CNT_WIDTH-1:0]       txn_count
);

    localparam int unsigned SelW = DATA_WIDTH / 8;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        wb_responder_channel #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_STALL  (MAX_STALL),
            .ERR_ENABLE (ERR_ENABLE),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .cyc_i       (wb_cyc[c]),
            .stb_i       (wb_stb[c]),
            .we_i        (wb_we[c]),
            .adr_i       (wb_adr[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .dat_i       (wb_dat_mosi[c*DATA_WIDTH +: DATA_WIDTH]),
            .sel_i       (wb_sel[c*SelW +: SelW]),
            .rsp_ready_i (rsp_ready[c]),
            .rsp_err_i   (rsp_err[c]),
            .rsp_data_i  (rsp_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .ack_o       (wb_ack[c]),
            .err_o       (wb_err[c]),
            .dat_o       (wb_dat_miso[c*DATA_WIDTH +: DATA_WIDTH]),
            .violation_o (violation[c]),
            .txn_count_o (txn_count[c*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_wb_bounded_responder.sv
// Directed bench. DUT A: 2 channels, MAX_STALL=3, ERR_ENABLE=1, 16-bit counters.
// DUT B: 1 channel, MAX_STALL=0, ERR_ENABLE=0, 2-bit counters.
// "Cycle k" of a test is the k-th clock period after the request is driven; outputs are
// sampled 1 time unit after the rising edge that opens each cycle.
module tb_wb_bounded_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic [1:0]  a_cyc, a_stb, a_we, a_ack, a_err, a_rdy, a_rerr, a_viol;
    logic [59:0] a_adr;
    logic [63:0] a_dmosi, a_dmiso, a_rdata;
    logic [7:0]  a_sel;
    logic [31:0] a_cnt;

    logic [0:0]  b_cyc, b_stb, b_we, b_ack, b_err, b_rdy, b_rerr, b_viol;
    logic [29:0] b_adr;
    logic [31:0] b_dmosi, b_dmiso, b_rdata;
    logic [3:0]  b_sel;
    logic [1:0]  b_cnt;

    wb_bounded_responder #(
        .CHANNELS(2), .ADDR_WIDTH(30), .DATA_WIDTH(32),
        .MAX_STALL(3), .ERR_ENABLE(1'b1), .CNT_WIDTH(16)
    ) u_dut_a (
        .clock(clock), .reset(reset),
        .wb_cyc(a_cyc), .wb_stb(a_stb), .wb_we(a_we), .wb_adr(a_adr),
        .wb_dat_mosi(a_dmosi), .wb_sel(a_sel), .wb_dat_miso(a_dmiso),
        .wb_ack(a_ack), .wb_err(a_err), .rsp_ready(a_rdy), .rsp_err(a_rerr),
        .rsp_data(a_rdata), .violation(a_viol), .txn_count(a_cnt)
    );

    wb_bounded_responder #(
        .CHANNELS(1), .ADDR_WIDTH(30), .DATA_WIDTH(32),
        .MAX_STALL(0), .ERR_ENABLE(1'b0), .CNT_WIDTH(2)
    ) u_dut_b (
        .clock(clock), .reset(reset),
        .wb_cyc(b_cyc), .wb_stb(b_stb), .wb_we(b_we), .wb_adr(b_adr),
        .wb_dat_mosi(b_dmosi), .wb_sel(b_sel), .wb_dat_miso(b_dmiso),
        .wb_ack(b_ack), .wb_err(b_err), .rsp_ready(b_rdy), .rsp_err(b_rerr),
        .rsp_data(b_rdata), .violation(b_viol), .txn_count(b_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_req(input int c, input logic [29:0] adr, input logic we,
                         input logic [31:0] wdat, input logic [31:0] rdat,
                         input logic rdy, input logic rerr);
        a_cyc[c] = 1'b1;
        a_stb[c] = 1'b1;
        a_we[c]  = we;
        a_adr[c*30 +: 30]   = adr;
        a_dmosi[c*32 +: 32] = wdat;
        a_sel[c*4 +: 4]     = 4'hF;
        a_rdata[c*32 +: 32] = rdat;
        a_rdy[c]  = rdy;
        a_rerr[c] = rerr;
    endtask

    task automatic a_drop(input int c);
        a_cyc[c]  = 1'b0;
        a_stb[c]  = 1'b0;
        a_rdy[c]  = 1'b0;
        a_rerr[c] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_cyc = '0; a_stb = '0; a_we = '0; a_adr = '0; a_dmosi = '0; a_sel = '0;
        a_rdy = '0; a_rerr = '0; a_rdata = '0;
        b_cyc = '0; b_stb = '0; b_we = '0; b_adr = '0; b_dmosi = '0; b_sel = '0;
        b_rdy = '0; b_rerr = '0; b_rdata = '0;
        tick();
        tick();
        check_eq("rst_a_ack", a_ack, 0);
        check_eq("rst_a_err", a_err, 0);
        check_eq("rst_a_dmiso", a_dmiso, 0);
        check_eq("rst_a_viol", a_viol, 0);
        check_eq("rst_a_cnt", a_cnt, 0);
        check_eq("rst_b_ack", b_ack, 0);
        check_eq("rst_b_cnt", b_cnt, 0);
        reset = 1'b0;

        // Minimum-latency read on channel 0.
        a_req(0, 30'h10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        check_eq("t1_c1_ack", a_ack, 0);
        tick();
        check_eq("t1_c2_ack", a_ack, 2'b01);
        check_eq("t1_c2_err", a_err, 0);
        check_eq("t1_c2_dat", a_dmiso[31:0], 32'hDEADBEEF);
        tick();
        check_eq("t1_c3_ack", a_ack, 0);
        check_eq("t1_c3_dat", a_dmiso, 0);
        check_eq("t1_c3_cnt", a_cnt[15:0], 1);
        a_drop(0);

        // Forced ACK after three stalls.
        tick();
        a_req(0, 30'h44, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq($sformatf("t2_c%0d_ack", k), a_ack[0], (k == 5));
            if (k == 5) check_eq("t2_c5_dat", a_dmiso[31:0], 32'h12345678);
        end
        tick();
        a_drop(0);
        check_eq("t2_cnt", a_cnt[15:0], 2);

        // Error injection on a write.
        tick();
        a_req(0, 30'h80, 1'b1, 32'h55AA55AA, 32'hFFFFFFFF, 1'b1, 1'b1);
        tick();
        tick();
        check_eq("t3_c2_err", a_err, 2'b01);
        check_eq("t3_c2_ack", a_ack, 0);
        check_eq("t3_c2_dat", a_dmiso, 0);
        tick();
        a_drop(0);
        check_eq("t3_cnt", a_cnt[15:0], 3);

        // Violations: channel 0 drops cyc, channel 1 changes address, both mid-WAIT.
        tick();
        a_req(0, 30'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        a_req(1, 30'h20, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        a_cyc[0] = 1'b0;
        a_adr[59:30] = 30'h21;
        tick();
        check_eq("t4_c3_viol", a_viol, 2'b11);
        check_eq("t4_c3_ack", a_ack, 0);
        a_drop(0);
        a_drop(1);
        tick();
        check_eq("t4_c4_viol", a_viol, 2'b11);
        check_eq("t4_c4_ack", a_ack, 0);
        check_eq("t4_c4_err", a_err, 0);
        check_eq("t4_cnt0", a_cnt[15:0], 3);
        check_eq("t4_cnt1", a_cnt[31:16], 0);

        // Independent channels: 0 stalls to the bound, 1 answers at once.
        tick();
        a_req(0, 30'h200, 1'b0, 32'h0, 32'hAAAA5555, 1'b0, 1'b0);
        a_req(1, 30'h204, 1'b0, 32'h0, 32'h0F0F0F0F, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq($sformatf("t5_c%0d_ack0", k), a_ack[0], (k == 5));
            check_eq($sformatf("t5_c%0d_ack1", k), a_ack[1], (k == 2));
            if (k == 2) check_eq("t5_dat1", a_dmiso[63:32], 32'h0F0F0F0F);
            if (k == 3) a_drop(1);
            if (k == 5) check_eq("t5_dat0", a_dmiso[31:0], 32'hAAAA5555);
        end
        tick();
        a_drop(0);
        check_eq("t5_cnt0", a_cnt[15:0], 4);
        check_eq("t5_cnt1", a_cnt[31:16], 1);
        check_eq("t5_viol_sticky", a_viol, 2'b11);

        // Reset in cycle 3 of a stalled transaction.
        tick();
        a_req(0, 30'h300, 1'b0, 32'h0, 32'h1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("t6_c%0d_ack", k), a_ack, 0);
        end
        reset = 1'b1;
        tick();
        check_eq("t6_c4_ack", a_ack, 0);
        check_eq("t6_c4_err", a_err, 0);
        check_eq("t6_c4_dat", a_dmiso, 0);
        check_eq("t6_c4_viol", a_viol, 0);
        check_eq("t6_c4_cnt", a_cnt, 0);
        reset = 1'b0;
        a_drop(0);
        tick();
        check_eq("t6_c5_ack", a_ack, 0);

        // DUT B: zero stall bound, errors disabled, back-to-back reads with stb held.
        tick();
        b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_adr = 30'h40; b_sel = 4'hF;
        b_rdata = 32'hCAFEF00D; b_rdy = 1'b0; b_rerr = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check_eq($sformatf("b1_c%0d_ack", k), b_ack, ((k % 3) == 2));
            check_eq($sformatf("b1_c%0d_err", k), b_err, 0);
            if (k == 2) check_eq("b1_dat", b_dmiso, 32'hCAFEF00D);
            if (k == 6) check_eq("b1_cnt2", b_cnt, 2);
            if (k == 9) check_eq("b1_cnt3", b_cnt, 3);
            if (k == 15) begin
                check_eq("b1_cnt_sat", b_cnt, 3);
                check_eq("b1_viol", b_viol, 0);
                b_cyc = 1'b0;
                b_stb = 1'b0;
            end
        end

        // DUT B: write with rsp_err set still ends in ACK, no read data.
        tick();
        b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_adr = 30'h44;
        b_dmosi = 32'h11111111; b_rdata = 32'h99999999; b_rdy = 1'b1; b_rerr = 1'b1;
        tick();
        tick();
        check_eq("b2_ack", b_ack, 1);
        check_eq("b2_err", b_err, 0);
        check_eq("b2_dat", b_dmiso, 0);
        tick();
        b_cyc = 1'b0;
        b_stb = 1'b0;
        check_eq("b2_cnt", b_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
